// File: rtl/coeff_pkg.sv
// rtl/coeff_pkg.sv - shared types and address map for the FIR coefficient bank
package coeff_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_LOADING = 2'd2,
    ST_FINISH  = 2'd3
  } coeff_state_t;

  localparam logic [2:0] ADDR_CTRL = 3'd4;

  localparam int CTRL_ARM_BIT     = 0;
  localparam int STAT_FLAG_BIT    = 0;
  localparam int STAT_TIMEOUT_BIT = 1;

endpackage

// File: rtl/sync_counter.sv
// rtl/sync_counter.sv - up-counter with sync clear, enable and terminal-count flag
module sync_counter #(
  parameter int WIDTH     = 8,
  parameter int MAX_COUNT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  // tc flags the enabled cycle whose increment would reach MAX_COUNT
  assign tc = en && (count == WIDTH'(MAX_COUNT - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/coeff_bank.sv
// rtl/coeff_bank.sv - FIR coefficient register bank with reload hand-off and watchdog
module coeff_bank
  import coeff_pkg::*;
#(
  parameter int COEFF_WIDTH    = 16,
  parameter int NUM_COEFFS     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [2:0]             wr_addr,
  input  logic [COEFF_WIDTH-1:0] wr_data,
  input  logic                   rd_en,
  input  logic [2:0]             rd_addr,
  output logic [COEFF_WIDTH-1:0] rd_data,
  input  logic                   load_coeff,
  input  logic [1:0]             coefficient_num,
  input  logic                   modwait,
  output logic                   new_coefficient_set,
  output logic [COEFF_WIDTH-1:0] fir_coefficient,
  output logic                   wr_err
);

  localparam int WD_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

  coeff_state_t           state, state_next;
  logic [COEFF_WIDTH-1:0] coeff [NUM_COEFFS];
  logic                   timeout;
  logic [COEFF_WIDTH-1:0] ctrl_status;
  logic [COEFF_WIDTH-1:0] rd_mux;

  logic coeff_wr, ctrl_wr, bad_wr, arm_req, arm_ok, timeout_clr, wr_err_next;
  logic [WD_WIDTH-1:0] wd_count;
  logic                wd_tc;

  assign coeff_wr    = wr_en && (wr_addr < ADDR_CTRL);
  assign ctrl_wr     = wr_en && (wr_addr == ADDR_CTRL);
  assign bad_wr      = wr_en && (wr_addr > ADDR_CTRL);
  assign arm_req     = ctrl_wr && wr_data[CTRL_ARM_BIT];
  assign arm_ok      = arm_req && (state == ST_IDLE);
  // An arm request rejected outside IDLE must not disturb the sticky timeout
  assign timeout_clr = ctrl_wr && !(arm_req && (state != ST_IDLE));
  assign wr_err_next = bad_wr || ((coeff_wr || arm_req) && (state != ST_IDLE));

  sync_counter #(
    .WIDTH     (WD_WIDTH),
    .MAX_COUNT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .clear (arm_ok),
    .en    (state == ST_ARMED),
    .count (wd_count),
    .tc    (wd_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (arm_ok) state_next = ST_ARMED;
      ST_ARMED: begin
        // A loader strobe wins over a watchdog expiry in the same cycle
        if (load_coeff)  state_next = ST_LOADING;
        else if (wd_tc)  state_next = ST_IDLE;
      end
      ST_LOADING: if (load_coeff && (coefficient_num == 2'(NUM_COEFFS - 1))) state_next = ST_FINISH;
      ST_FINISH:  if (!modwait) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    new_coefficient_set = (state != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_COEFFS; i++) coeff[i] <= '0;
      timeout <= 1'b0;
      wr_err  <= 1'b0;
    end else begin
      if (coeff_wr && (state == ST_IDLE)) coeff[wr_addr[1:0]] <= wr_data;
      if (state == ST_ARMED && !load_coeff && wd_tc) timeout <= 1'b1;
      else if (timeout_clr)                           timeout <= 1'b0;
      wr_err <= wr_err_next;
    end
  end

  always_comb begin
    ctrl_status                   = '0;
    ctrl_status[STAT_FLAG_BIT]    = new_coefficient_set;
    ctrl_status[STAT_TIMEOUT_BIT] = timeout;
  end

  always_comb begin
    rd_mux = '0;
    if (rd_addr < ADDR_CTRL)       rd_mux = coeff[rd_addr[1:0]];
    else if (rd_addr == ADDR_CTRL) rd_mux = ctrl_status;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_mux;
    end
  end

  assign fir_coefficient = coeff[coefficient_num];

endmodule

// File: tb/tb_coeff_bank.sv
// tb/tb_coeff_bank.sv - self-checking bench for coeff_bank
module tb_coeff_bank;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        rd_en;
  logic [2:0]  rd_addr;
  logic [15:0] rd_data;
  logic        load_coeff;
  logic [1:0]  coefficient_num;
  logic        modwait;
  logic        new_coefficient_set;
  logic [15:0] fir_coefficient;
  logic        wr_err;

  int n_checks;
  int n_fail;
  logic [15:0] rd_q [$];
  logic [15:0] fir_q [$];
  logic [15:0] model [4];
  logic [15:0] exp_v;

  coeff_bank #(
    .COEFF_WIDTH    (16),
    .NUM_COEFFS     (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .wr_en               (wr_en),
    .wr_addr             (wr_addr),
    .wr_data             (wr_data),
    .rd_en               (rd_en),
    .rd_addr             (rd_addr),
    .rd_data             (rd_data),
    .load_coeff          (load_coeff),
    .coefficient_num     (coefficient_num),
    .modwait             (modwait),
    .new_coefficient_set (new_coefficient_set),
    .fir_coefficient     (fir_coefficient),
    .wr_err              (wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd_issue(input logic [2:0] a, input logic [15:0] e);
    rd_en = 1'b1; rd_addr = a;
    rd_q.push_back(e);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_checks++;
    if (new_coefficient_set !== 1'b0 || wr_err !== 1'b0 || rd_data !== 16'h0) begin
      $display("FAIL reset_outputs: flag=%b wr_err=%b rd_data=%h, want 0 0 0000",
               new_coefficient_set, wr_err, rd_data);
      n_fail++;
    end
    n_checks++;
    if (fir_coefficient !== 16'h0) begin
      $display("FAIL reset_fir: got %h want 0000", fir_coefficient); n_fail++;
    end
    rd_issue(3'd4, 16'h0000);
    exp_v = rd_q.pop_front();
    n_checks++;
    if (rd_data !== exp_v) begin
      $display("FAIL reset_ctrl_read: got %h want %h", rd_data, exp_v); n_fail++;
    end
  endtask

  task automatic test_write_read();
    model[0] = 16'h1111; model[1] = 16'h2222; model[2] = 16'h3333; model[3] = 16'h4444;
    for (int i = 0; i < 4; i++) bus_write(3'(i), model[i]);
    for (int i = 0; i < 4; i++) begin
      rd_issue(3'(i), model[i]);
      exp_v = rd_q.pop_front();
      n_checks++;
      if (rd_data !== exp_v) begin
        $display("FAIL read_coeff%0d: got %h want %h", i, rd_data, exp_v); n_fail++;
      end
    end
    tick();
    n_checks++;
    if (rd_data !== 16'h4444) begin
      $display("FAIL rd_hold: got %h want 4444", rd_data); n_fail++;
    end
    rd_issue(3'd7, 16'h0000);
    exp_v = rd_q.pop_front();
    n_checks++;
    if (rd_data !== exp_v) begin
      $display("FAIL read_invalid: got %h want %h", rd_data, exp_v); n_fail++;
    end
    // simultaneous read and write of addr 2 returns the old value
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h5555;
    rd_issue(3'd2, 16'h3333);
    wr_en = 1'b0;
    exp_v = rd_q.pop_front();
    n_checks++;
    if (rd_data !== exp_v) begin
      $display("FAIL read_during_write: got %h want %h", rd_data, exp_v); n_fail++;
    end
    rd_issue(3'd2, 16'h5555);
    exp_v = rd_q.pop_front();
    n_checks++;
    if (rd_data !== exp_v) begin
      $display("FAIL read_after_write: got %h want %h", rd_data, exp_v); n_fail++;
    end
    bus_write(3'd2, 16'h3333);
  endtask

  task automatic test_load_and_finish();
    bus_write(3'd4, 16'h0001);
    n_checks++;
    if (new_coefficient_set !== 1'b1) begin
      $display("FAIL arm_flag: got %b want 1", new_coefficient_set); n_fail++;
    end
    for (int i = 0; i < 4; i++) begin
      load_coeff = 1'b1; coefficient_num = 2'(i);
      if (i == 3) modwait = 1'b1;
      fir_q.push_back(model[i]);
      #1;
      exp_v = fir_q.pop_front();
      n_checks++;
      if (fir_coefficient !== exp_v) begin
        $display("FAIL fir_coeff%0d: got %h want %h", i, fir_coefficient, exp_v); n_fail++;
      end
      tick();
      load_coeff = 1'b0;
    end
    for (int i = 0; i < 3; i++) tick();
    n_checks++;
    if (new_coefficient_set !== 1'b1) begin
      $display("FAIL flag_during_modwait: got %b want 1", new_coefficient_set); n_fail++;
    end
    modwait = 1'b0;
    tick();
    n_checks++;
    if (new_coefficient_set !== 1'b0) begin
      $display("FAIL flag_after_modwait: got %b want 0", new_coefficient_set); n_fail++;
    end
  endtask

  task automatic test_wr_err();
    bus_write(3'd4, 16'h0001);
    load_coeff = 1'b1; coefficient_num = 2'd0;
    tick();
    load_coeff = 1'b0;
    bus_write(3'd1, 16'hBEEF);
    n_checks++;
    if (wr_err !== 1'b1) begin
      $display("FAIL wr_err_loading: got %b want 1", wr_err); n_fail++;
    end
    tick();
    n_checks++;
    if (wr_err !== 1'b0) begin
      $display("FAIL wr_err_one_cycle: got %b want 0", wr_err); n_fail++;
    end
    bus_write(3'd4, 16'h0001);
    n_checks++;
    if (wr_err !== 1'b1) begin
      $display("FAIL wr_err_rearm: got %b want 1", wr_err); n_fail++;
    end
    // finish the sequence with modwait already low: flag falls two cycles after the last strobe
    for (int i = 1; i < 4; i++) begin
      load_coeff = 1'b1; coefficient_num = 2'(i);
      tick();
    end
    load_coeff = 1'b0;
    n_checks++;
    if (new_coefficient_set !== 1'b1) begin
      $display("FAIL finish_one_cycle: got %b want 1", new_coefficient_set); n_fail++;
    end
    tick();
    n_checks++;
    if (new_coefficient_set !== 1'b0) begin
      $display("FAIL finish_exit: got %b want 0", new_coefficient_set); n_fail++;
    end
    rd_issue(3'd1, 16'h2222);
    exp_v = rd_q.pop_front();
    n_checks++;
    if (rd_data !== exp_v) begin
      $display("FAIL coeff1_protected: got %h want %h", rd_data, exp_v); n_fail++;
    end
    bus_write(3'd6, 16'h1234);
    n_checks++;
    if (wr_err !== 1'b1) begin
      $display("FAIL wr_err_addr6: got %b want 1", wr_err); n_fail++;
    end
    tick();
    n_checks++;
    if (wr_err !== 1'b0) begin
      $display("FAIL wr_err_addr6_clear: got %b want 0", wr_err); n_fail++;
    end
  endtask

  task automatic test_timeout();
    int cycles;
    bus_write(3'd4, 16'h0001);
    cycles = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (new_coefficient_set === 1'b0 && cycles == 0) cycles = k;
    end
    n_checks++;
    if (cycles != 8) begin
      $display("FAIL timeout_length: flag fell after %0d cycles want 8", cycles); n_fail++;
    end
    rd_issue(3'd4, 16'h0002);
    exp_v = rd_q.pop_front();
    n_checks++;
    if (rd_data !== exp_v) begin
      $display("FAIL timeout_status: got %h want %h", rd_data, exp_v); n_fail++;
    end
    bus_write(3'd4, 16'h0000);
    rd_issue(3'd4, 16'h0000);
    exp_v = rd_q.pop_front();
    n_checks++;
    if (rd_data !== exp_v) begin
      $display("FAIL timeout_cleared: got %h want %h", rd_data, exp_v); n_fail++;
    end
  endtask

  task automatic test_reset_mid();
    bus_write(3'd4, 16'h0001);
    rst = 1'b1; load_coeff = 1'b1; coefficient_num = 2'd3;
    tick();
    rst = 1'b0; load_coeff = 1'b0;
    n_checks++;
    if (new_coefficient_set !== 1'b0 || fir_coefficient !== 16'h0) begin
      $display("FAIL reset_mid: flag=%b fir=%h want 0 0000", new_coefficient_set, fir_coefficient);
      n_fail++;
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0; load_coeff = 1'b0; coefficient_num = '0; modwait = 1'b0;
    test_reset();
    test_write_read();
    test_load_and_finish();
    test_wr_err();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/coeff_bank.md
# coeff_bank

Coefficient register bank and hand-off controller for the FIR filter's AHB-Lite slave. It stores the filter coefficients written by the bus front end and raises `new_coefficient_set` when the host arms a reload. It drives the addressed coefficient onto `fir_coefficient` while the downstream coefficient loader steps through `coefficient_num`. It drops the flag once the last coefficient has been taken and the datapath is idle, and includes a watchdog that abandons an arm the loader never services.

## Interface
- `COEFF_WIDTH`, 16: coefficient width in bits.
- `NUM_COEFFS`, 4: number of coefficients; must equal the loader's count (rollover 3 → 4).
- `TIMEOUT_CYCLES`, 255: maximum cycles in ARMED without a `load_coeff` pulse.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `wr_en`  in  1  write strobe from the bus front end.
- `wr_addr`  in  3  0..3 select a coefficient; 4 is CTRL; 5..7 are invalid.
- `wr_data`  in  COEFF_WIDTH  write data.
- `rd_en`  in  1  read strobe.
- `rd_addr`  in  3  read address, same map as `wr_addr`.
- `rd_data`  out  COEFF_WIDTH  registered read data.
- `load_coeff`  in  1  loader strobe; datapath samples `fir_coefficient` in this cycle.
- `coefficient_num`  in  2  loader index.
- `modwait`  in  1  datapath busy.
- `new_coefficient_set`  out  1  reload request to the loader.
- `fir_coefficient`  out  COEFF_WIDTH  `coeff[coefficient_num]`, combinational mux of registers.
- `wr_err`  out  1  one-cycle pulse when a write is rejected.

## Operation
- States:
  - IDLE: flag 0.
  - ARMED: flag 1, waiting for the loader.
  - LOADING: flag 1.
  - FINISH: flag 1, waiting for `modwait` = 0.
- Transitions:
  - IDLE → ARMED: write to CTRL with `wr_data[0]` = 1.
  - ARMED → LOADING: first cycle with `load_coeff` = 1.
  - ARMED → IDLE on timeout: watchdog reaches `TIMEOUT_CYCLES`; sets the sticky `timeout` bit.
  - LOADING → FINISH: `load_coeff` = 1 with `coefficient_num` = NUM_COEFFS-1.
  - FINISH → IDLE: `modwait` = 0.
- Coefficient writes (addr 0..3):
  - Accepted only in IDLE.
  - In any other state the register is unchanged and `wr_err` pulses.
- CTRL write:
  - bit0 = 1 in IDLE arms the bank and clears `timeout`.
  - bit0 = 1 outside IDLE is ignored and `wr_err` pulses.
  - bit0 = 0 has no effect except clearing `timeout`.
- Writes to addr 5..7: ignored, `wr_err` pulses.
- Reads:
  - addr 0..3 return the coefficient.
  - addr 4 returns {zeros, `timeout`, `new_coefficient_set`}.
  - addr 5..7 return 0.
  - `rd_data` holds its value when `rd_en` = 0.
- Watchdog:
  - Counter runs only in ARMED and is cleared on entry to ARMED.
  - Timeout fires when the count equals `TIMEOUT_CYCLES`, i.e. ARMED lasts exactly `TIMEOUT_CYCLES` cycles.
- `load_coeff` outside ARMED/LOADING does not change state.
- `fir_coefficient` always reflects `coefficient_num`, independent of state.

## Timing
- Reset values:
  - All coefficients, `rd_data`, `wr_err`, `new_coefficient_set`, `timeout` and the watchdog count are 0.
  - State is IDLE.
  - Reset asserted mid-operation takes effect at the next edge and overrides all other inputs.
- Latency:
  - Write takes effect at the next edge.
  - `new_coefficient_set` rises 1 cycle after the arming write.
  - `rd_data` is valid 1 cycle after `rd_en`.
  - `wr_err` is asserted the cycle after the rejected write.
- Flag fall:
  - Falls 1 cycle after the FINISH edge where `modwait` = 0.
  - If `modwait` is already 0 on the final `load_coeff`, the block still spends one cycle in FINISH, so the flag falls 2 cycles after that strobe.
- Simultaneous read and write of the same address: the read returns the old value.

## Structure
- Package `coeff_pkg` holds:
  - The state enum.
  - `ADDR_CTRL` = 3'd4.
  - `CTRL_ARM_BIT` = 0 and the status bit positions 0 (flag) and 1 (timeout).
- One sub-module: `sync_counter`, a parameterised up-counter with synchronous active-high reset and clear, enable and a terminal-count flag. It is used for the watchdog.

## Test plan
1. Assert `rst` for 2 cycles, then release → every output is 0 and the CTRL read returns 0x0000.
2. Write 0x1111, 0x2222, 0x3333, 0x4444 to addr 0..3, then read addr 0..3 → the same values appear on `rd_data` one cycle after each `rd_en`.
3. Arm the bank, then drive `load_coeff` pulses with `coefficient_num` 0..3 → `fir_coefficient` reads 0x1111..0x4444 in the strobe cycles.
4. Continue scenario 3: hold `modwait` high 3 cycles after the last pulse, then drop it → `new_coefficient_set` is 0 one cycle after `modwait` falls.
5. In LOADING, write 0xBEEF to addr 1 → `wr_err` is 1 for exactly one cycle and addr 1 still reads 0x2222; a write to addr 6 in IDLE also pulses `wr_err`.
6. With `TIMEOUT_CYCLES` = 8, arm with no loader activity → the flag drops after 8 cycles and CTRL reads 0x0002; a CTRL write of 0 then makes CTRL read 0x0000.
